// File: rtl/tstate_wb_sequencer_if.sv
// Bus bundle between the 6502C random-logic decoder and the T-state/writeback sequencer.
// WB_BYPASS_EN selects bypass_hit (bypass build) or stall_req (default build) as the hazard output.
interface tstate_wb_sequencer_if #(
  parameter int NUM_T    = 7,
  parameter int NUM_DEST = 3
) ();
  logic                rdy;
  logic                last_cyc;
  logic                wb_req;
  logic [NUM_DEST-1:0] wb_dest;
  logic [NUM_DEST-1:0] src_rd;
  logic [NUM_T-1:0]    t_state;
  logic [NUM_DEST-1:0] wb_en;
  logic                q_full;
  logic                t_ovf;
`ifdef WB_BYPASS_EN
  logic [NUM_DEST-1:0] bypass_hit;
`else
  logic                stall_req;
`endif

  // Decoder side: drives cycle qualifiers, observes sequencing and writeback
  modport master (
    output rdy, last_cyc, wb_req, wb_dest, src_rd,
`ifdef WB_BYPASS_EN
    input  bypass_hit,
`else
    input  stall_req,
`endif
    input  t_state, wb_en, q_full, t_ovf
  );

  // Sequencer side
  modport slave (
    input  rdy, last_cyc, wb_req, wb_dest, src_rd,
`ifdef WB_BYPASS_EN
    output bypass_hit,
`else
    output stall_req,
`endif
    output t_state, wb_en, q_full, t_ovf
  );
endinterface

// File: rtl/tstate_wb_sequencer.sv
// T-state sequencer with deferred register writeback (fetch/execute overlap).
// One-hot T-state generation, sticky overrun flag, and a small FIFO of pending
// one-hot writeback destinations that fire in slot WB_SLOT or on last_cyc.
// Optional feature macro: WB_BYPASS_EN (bypass_hit output replaces stall_req).
module tstate_wb_sequencer #(
  parameter int NUM_T    = 7,
  parameter int NUM_DEST = 3,
  parameter int WB_SLOT  = 2,
  parameter int Q_DEPTH  = 2
) (
  input  logic                  phi1,
  input  logic                  rst,
  tstate_wb_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(Q_DEPTH + 1);
  localparam logic [NUM_T-1:0]    T1_ONEHOT = {{(NUM_T-2){1'b0}}, 2'b10};
  localparam logic [NUM_DEST-1:0] DEST_ONE  = {{(NUM_DEST-1){1'b0}}, 1'b1};

  logic [NUM_T-1:0]    t_state_q, t_state_d;
  logic                t_ovf_q, t_ovf_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [NUM_DEST-1:0] entry_q [Q_DEPTH];
  logic [NUM_DEST-1:0] entry_d [Q_DEPTH];

  logic                dest_onehot;
  logic                fire;
  logic                capture;
  logic [CNT_W-1:0]    count_pop;
  logic [NUM_DEST-1:0] pend_masked [Q_DEPTH];
  logic [NUM_DEST-1:0] pend_or;
  logic [NUM_DEST-1:0] hit;

  // A malformed (zero or multi-hot) destination is silently dropped on capture.
  assign dest_onehot = (bus.wb_dest != '0) &&
                       ((bus.wb_dest & (bus.wb_dest - DEST_ONE)) == '0);

  // last_cyc also fires so an instruction shorter than WB_SLOT still flushes its predecessor.
  assign fire    = bus.rdy && (count_q != '0) && (t_state_q[WB_SLOT] || bus.last_cyc);
  assign capture = bus.rdy && bus.last_cyc && bus.wb_req && dest_onehot;

  // Valid entries that are still pending after this cycle (the firing head is excluded).
  generate
    for (genvar gi = 0; gi < Q_DEPTH; gi++) begin : g_pend
      assign pend_masked[gi] = ((count_q > CNT_W'(gi)) && !(fire && (gi == 0)))
                               ? entry_q[gi] : '0;
    end
  endgenerate

  // OR-reduce the pending destinations into one hazard mask.
  always_comb begin
    pend_or = '0;
    for (int i = 0; i < Q_DEPTH; i++) begin
      pend_or = pend_or | pend_masked[i];
    end
  end

  assign hit = bus.src_rd & pend_or;

  // Next T-state and sticky overrun flag; everything holds while rdy is low.
  always_comb begin
    t_state_d = t_state_q;
    t_ovf_d   = t_ovf_q;
    if (bus.rdy) begin
      if (bus.last_cyc) begin
        t_state_d = T1_ONEHOT;
      end else if (t_state_q[NUM_T-1]) begin
        t_state_d = T1_ONEHOT;
        t_ovf_d   = 1'b1;
      end else begin
        t_state_d = t_state_q << 1;
      end
    end
  end

  // Queue next state: pop the fired head first, then append the captured entry behind what remains.
  always_comb begin
    for (int i = 0; i < Q_DEPTH; i++) begin
      entry_d[i] = entry_q[i];
    end
    count_pop = count_q;
    if (fire) begin
      for (int i = 0; i < Q_DEPTH - 1; i++) begin
        entry_d[i] = entry_q[i+1];
      end
      entry_d[Q_DEPTH-1] = '0;
      count_pop = count_q - CNT_W'(1);
    end
    count_d = count_pop;
    // A full queue without a pop cannot see a capture because last_cyc always fires;
    // the guard just keeps an illegal sequence from corrupting the count.
    if (capture && (count_pop < CNT_W'(Q_DEPTH))) begin
      for (int i = 0; i < Q_DEPTH; i++) begin
        if (count_pop == CNT_W'(i)) begin
          entry_d[i] = bus.wb_dest;
        end
      end
      count_d = count_pop + CNT_W'(1);
    end
  end

  // State registers; reset lands in T1 (fetch) and discards any pending writebacks.
  always_ff @(posedge phi1 or posedge rst) begin
    if (rst) begin
      t_state_q <= T1_ONEHOT;
      t_ovf_q   <= 1'b0;
      count_q   <= '0;
      for (int i = 0; i < Q_DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      t_state_q <= t_state_d;
      t_ovf_q   <= t_ovf_d;
      count_q   <= count_d;
      for (int i = 0; i < Q_DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  assign bus.t_state = t_state_q;
  assign bus.t_ovf   = t_ovf_q;
  assign bus.q_full  = (count_q == CNT_W'(Q_DEPTH));
  assign bus.wb_en   = fire ? entry_q[0] : '0;

`ifdef WB_BYPASS_EN
  // Datapath forwards SB onto the read bus for these registers.
  assign bus.bypass_hit = hit;
`else
  // System holds rdy low while a read depends on a not-yet-written register.
  assign bus.stall_req = |hit;
`endif

endmodule

// File: tb/tb_tstate_wb_sequencer.sv
// Directed bench for tstate_wb_sequencer: default-depth instance plus a depth-1 instance
// (shared stimulus) so q_full can be observed.
module tb_tstate_wb_sequencer;

  logic phi1;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  tstate_wb_sequencer_if #(.NUM_T(7), .NUM_DEST(3)) bus0 ();
  tstate_wb_sequencer_if #(.NUM_T(7), .NUM_DEST(3)) bus1 ();

  tstate_wb_sequencer #(.NUM_T(7), .NUM_DEST(3), .WB_SLOT(2), .Q_DEPTH(2)) u_dut (
    .phi1 (phi1),
    .rst  (rst),
    .bus  (bus0.slave)
  );

  tstate_wb_sequencer #(.NUM_T(7), .NUM_DEST(3), .WB_SLOT(2), .Q_DEPTH(1)) u_dut_d1 (
    .phi1 (phi1),
    .rst  (rst),
    .bus  (bus1.slave)
  );

  assign bus1.rdy      = bus0.rdy;
  assign bus1.last_cyc = bus0.last_cyc;
  assign bus1.wb_req   = bus0.wb_req;
  assign bus1.wb_dest  = bus0.wb_dest;
  assign bus1.src_rd   = bus0.src_rd;

  initial begin
    phi1 = 1'b0;
    forever #5 phi1 = ~phi1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic drive(input logic r, input logic l, input logic q,
                       input logic [2:0] d, input logic [2:0] s);
    bus0.rdy      = r;
    bus0.last_cyc = l;
    bus0.wb_req   = q;
    bus0.wb_dest  = d;
    bus0.src_rd   = s;
  endtask

  task automatic tick();
    @(posedge phi1);
    #1;
  endtask

  task automatic mid();
    @(negedge phi1);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    #1 rst = 1'b1;
    #1 rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    #12 rst = 1'b0;
    tick();

    // Reset state
    check_val("rst_t_state", 32'(bus0.t_state), 32'h02);
    check_val("rst_wb_en",   32'(bus0.wb_en),   32'h0);
    check_val("rst_q_full",  32'(bus0.q_full),  32'h0);
    check_val("rst_t_ovf",   32'(bus0.t_ovf),   32'h0);
`ifndef WB_BYPASS_EN
    check_val("rst_stall",   32'(bus0.stall_req), 32'h0);
`endif

    // 1: async reset mid-cycle, then overrun without last_cyc
    drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    tick();
    check_val("t1_pre_rst_T2", 32'(bus0.t_state), 32'h04);
    #2 rst = 1'b1;
    #1;
    check_val("t1_async_rst", 32'(bus0.t_state), 32'h02);
    rst = 1'b0;
    #1;
    for (int i = 2; i <= 6; i++) begin
      tick();
      check_val($sformatf("t1_adv_T%0d", i), 32'(bus0.t_state), 32'(1 << i));
      check_val($sformatf("t1_ovf_T%0d", i), 32'(bus0.t_ovf), 32'h0);
    end
    tick();
    check_val("t1_wrap_T1", 32'(bus0.t_state), 32'h02);
    check_val("t1_ovf_set", 32'(bus0.t_ovf),   32'h1);
    tick();
    check_val("t1_ovf_sticky", 32'(bus0.t_ovf), 32'h1);

    // 2: ADC-like retire into AC, fires at T2 of the next instruction
    do_reset();
    check_val("t2_ovf_cleared", 32'(bus0.t_ovf), 32'h0);
    drive(1'b1, 1'b1, 1'b1, 3'b001, 3'b000);
    mid();
    check_val("t2_cap_wb_en", 32'(bus0.wb_en), 32'h0);
    tick();
    check_val("t2_d1_full", 32'(bus1.q_full), 32'h1);
    check_val("t2_d2_notfull", 32'(bus0.q_full), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    mid();
    check_val("t2_T1_wb_en", 32'(bus0.wb_en), 32'h0);
    tick();
    mid();
    check_val("t2_T2_state", 32'(bus0.t_state), 32'h04);
    check_val("t2_T2_wb_en", 32'(bus0.wb_en), 32'h1);
    tick();
    mid();
    check_val("t2_T3_wb_en", 32'(bus0.wb_en), 32'h0);
    check_val("t2_d1_empty", 32'(bus1.q_full), 32'h0);

    // 3: two-cycle instruction retiring X then Y back-to-back
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 3'b010, 3'b000);
    mid();
    check_val("t3_capX_wb_en", 32'(bus0.wb_en), 32'h0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 3'b100, 3'b000);
    mid();
    check_val("t3_fireX", 32'(bus0.wb_en), 32'h2);
    tick();
    check_val("t3_occ_not_full", 32'(bus0.q_full), 32'h0);
    check_val("t3_d1_still_full", 32'(bus1.q_full), 32'h1);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    mid();
    check_val("t3_T1_wb_en", 32'(bus0.wb_en), 32'h0);
    tick();
    mid();
    check_val("t3_fireY", 32'(bus0.wb_en), 32'h4);
    check_val("t3_d1_fireY", 32'(bus1.wb_en), 32'h4);
    tick();
    mid();
    check_val("t3_T3_wb_en", 32'(bus0.wb_en), 32'h0);
    check_val("t3_d1_empty", 32'(bus1.q_full), 32'h0);

    // 4: stall at the T2 slot with a pending AC entry
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 3'b001, 3'b000);
    tick();
    drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    tick();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    for (int i = 0; i < 3; i++) begin
      mid();
      check_val($sformatf("t4_hold_state%0d", i), 32'(bus0.t_state), 32'h04);
      check_val($sformatf("t4_hold_wb_en%0d", i), 32'(bus0.wb_en), 32'h0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    mid();
    check_val("t4_release_wb_en", 32'(bus0.wb_en), 32'h1);
    tick();
    check_val("t4_release_T3", 32'(bus0.t_state), 32'h08);

    // 5: pending X read in T1
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 3'b010, 3'b000);
    tick();
    drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b010);
    mid();
`ifdef WB_BYPASS_EN
    check_val("t5_bypass_T1", 32'(bus0.bypass_hit), 32'h2);
`else
    check_val("t5_stall_T1", 32'(bus0.stall_req), 32'h1);
`endif
    check_val("t5_T1_wb_en", 32'(bus0.wb_en), 32'h0);
    tick();
    mid();
    check_val("t5_fireX", 32'(bus0.wb_en), 32'h2);
`ifdef WB_BYPASS_EN
    check_val("t5_bypass_T2", 32'(bus0.bypass_hit), 32'h0);
`else
    check_val("t5_stall_T2", 32'(bus0.stall_req), 32'h0);
`endif

    // 6: non-one-hot destination dropped; reset discards a pending entry
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 3'b011, 3'b000);
    tick();
    check_val("t6_no_capture", 32'(bus1.q_full), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    tick();
    mid();
    check_val("t6_T2_wb_en", 32'(bus0.wb_en), 32'h0);
    drive(1'b1, 1'b1, 1'b1, 3'b001, 3'b000);
    tick();
    check_val("t6_queued", 32'(bus1.q_full), 32'h1);
    do_reset();
    check_val("t6_rst_q_full", 32'(bus1.q_full), 32'h0);
    drive(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
    for (int i = 1; i <= 3; i++) begin
      mid();
      check_val($sformatf("t6_lost_T%0d", i), 32'(bus0.wb_en | bus1.wb_en), 32'h0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
